grf_mp: RTL and testbench

- Parametrised successor to the single-write, two-read general register file.
- Configurable data width, depth, and number of read and write ports.
- Optional write-to-read bypass, optional hardwired-zero register 0.
- Per-register pending scoreboard (set at issue, cleared at writeback) so a pipelined or dual-issue core can read operands and hazard status from one block.

---
 rtl/grf_mp_pkg.sv | 13 +
 rtl/grf_wr_arb.sv | 33 +++
 rtl/grf_mp.sv | 118 +++++++++++
 tb/tb_grf_mp.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/grf_mp_pkg.sv
// Shared constants for the multi-port register file and the pipeline hazard unit.
// Defaults for geometry plus the ZERO_REG / BYPASS enable encodings.
package grf_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  localparam bit ZERO_REG_ON  = 1'b1;
  localparam bit ZERO_REG_OFF = 1'b0;
  localparam bit BYPASS_ON    = 1'b1;
  localparam bit BYPASS_OFF   = 1'b0;
endpackage

// File: rtl/grf_wr_arb.sv
// Resolves all write ports against one register address: hit flag plus winning data.
// Purely combinational; the highest-numbered matching port wins, address 0 never hits under ZERO_REG.
module grf_wr_arb
  import grf_mp_pkg::*;
#(
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter bit ZERO_REG = ZERO_REG_ON
) (
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     o_hit,
  output logic [DATA_W-1:0]        o_data
);
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // Ascending scan so a later match overwrites an earlier one.
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[j*DATA_W +: DATA_W];
      end
    end
    if (ZERO_REG && (i_addr == '0)) begin
      o_hit  = 1'b0;
      o_data = '0;
    end
  end
endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with write-to-read bypass and a per-register pending scoreboard.
// Reads are combinational; writes and scoreboard updates land on the rising edge.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit BYPASS   = BYPASS_ON,
  parameter bit ZERO_REG = ZERO_REG_ON
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic [ADDR_W:0]          pend_count
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W:0]   r_pend_count;

  logic [DEPTH-1:0]  w_wr_hit;
  logic [DATA_W-1:0] w_wr_dat [DEPTH];
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [ADDR_W:0]   w_pend_cnt_nxt;

  // One resolver per storage location drives the update enables.
  for (genvar a = 0; a < DEPTH; a++) begin : g_store_arb
    grf_wr_arb #(
      .NUM_WR  (NUM_WR),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ZERO_REG(ZERO_REG)
    ) u_arb (
      .i_wr_en  (wr_en),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .i_addr   (ADDR_W'(a)),
      .o_hit    (w_wr_hit[a]),
      .o_data   (w_wr_dat[a])
    );
  end

  // Set is applied after clear so a newer producer issued this cycle keeps the register pending.
  always_comb begin
    w_pend_nxt     = r_pend;
    w_pend_cnt_nxt = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (w_wr_hit[a]) begin
        w_pend_nxt[a] = 1'b0;
      end
      if (pend_set && (pend_addr == ADDR_W'(a)) && !(ZERO_REG && (a == 0))) begin
        w_pend_nxt[a] = 1'b1;
      end
      w_pend_cnt_nxt = w_pend_cnt_nxt + (ADDR_W + 1)'(w_pend_nxt[a]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        r_regs[a] <= '0;
      end
      r_pend       <= '0;
      r_pend_count <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (w_wr_hit[a]) begin
          r_regs[a] <= w_wr_dat[a];
        end
      end
      r_pend       <= w_pend_nxt;
      r_pend_count <= w_pend_cnt_nxt;
    end
  end

  assign pend_count = r_pend_count;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_byp_dat;
    logic              w_fwd;
    logic [DATA_W-1:0] w_stored;

    assign w_raddr = rd_addr[k*ADDR_W +: ADDR_W];

    grf_wr_arb #(
      .NUM_WR  (NUM_WR),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ZERO_REG(ZERO_REG)
    ) u_byp_arb (
      .i_wr_en  (wr_en),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .i_addr   (w_raddr),
      .o_hit    (w_byp_hit),
      .o_data   (w_byp_dat)
    );

    // Forwarding is suppressed during reset so every address reads 0 while it is held.
    assign w_fwd    = BYPASS && w_byp_hit && !reset;
    assign w_stored = (ZERO_REG && (w_raddr == '0)) ? '0 : r_regs[w_raddr];

    assign rd_data[k*DATA_W +: DATA_W] = w_fwd ? w_byp_dat : w_stored;
    assign rd_pending[k]               = r_pend[w_raddr] && !w_fwd;
  end
endmodule

// File: tb/tb_grf_mp.sv
// Directed vector bench for grf_mp: one BYPASS=1 and one BYPASS=0 instance driven in parallel.
module tb_grf_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_pend_b, rd_pend_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grf_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_pending(rd_pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_count(cnt_b)
  );

  grf_mp #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_pending(rd_pend_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_count(cnt_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic        ps;  logic [4:0]  pa;
    logic [4:0]  ra0; logic [4:0]  ra1;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic [1:0]  e_pend;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vt[12];

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ps, input logic [4:0] pa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en     = we;
    wr_addr   = {wa1, wa0};
    wr_data   = {wd1, wd0};
    pend_set  = ps;
    pend_addr = pa;
    rd_addr   = {ra1, ra0};
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    check("reset_cnt", 32'(cnt_b), 32'd0);
    check("reset_rd0", rd_data_b[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //          we     wa0  wd0           wa1  wd1           ps  pa    ra0  ra1  e_rd0         e_rd1    e_pend e_cnt
    vt[0]  = '{2'b01, 5'd5, 32'h00001234, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd6, 32'h00001234, 32'h0,  2'b00, 6'd0};
    vt[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1, 5'd9, 5'd5, 5'd9, 32'h00001234, 32'h0,  2'b00, 6'd1};
    vt[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1, 5'd10,5'd9, 5'd10,32'h0,        32'h0,  2'b01, 6'd2};
    vt[3]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h00000099, 0, 5'd0, 5'd9, 5'd10,32'h00000099, 32'h0,  2'b10, 6'd1};
    vt[4]  = '{2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF, 0, 5'd0, 5'd7, 5'd10,32'h5555FFFF, 32'h0,  2'b10, 6'd1};
    vt[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd9, 32'h5555FFFF, 32'h99, 2'b00, 6'd1};
    vt[6]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,  2'b00, 6'd1};
    vt[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd10,32'h0,        32'h0,  2'b10, 6'd1};
    vt[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1, 5'd4, 5'd4, 5'd3, 32'h0,        32'h0,  2'b00, 6'd2};
    vt[9]  = '{2'b01, 5'd4, 32'h00004444, 5'd0, 32'h0,        1, 5'd4, 5'd4, 5'd10,32'h00004444, 32'h0,  2'b10, 6'd2};
    vt[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1, 5'd10,5'd4, 5'd10,32'h00004444, 32'h0,  2'b11, 6'd2};
    vt[11] = '{2'b11, 5'd12,32'h0000000C, 5'd13,32'h0000000D, 0, 5'd0, 5'd13,5'd12,32'h0000000D, 32'hC,  2'b00, 6'd2};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i].we, vt[i].wa0, vt[i].wd0, vt[i].wa1, vt[i].wd1,
            vt[i].ps, vt[i].pa, vt[i].ra0, vt[i].ra1);
      #1;
      check($sformatf("v%0d_rd0", i), rd_data_b[31:0], vt[i].e_rd0);
      check($sformatf("v%0d_rd1", i), rd_data_b[63:32], vt[i].e_rd1);
      check($sformatf("v%0d_pend", i), 32'(rd_pend_b), 32'(vt[i].e_pend));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i), 32'(cnt_b), 32'(vt[i].e_cnt));
      check($sformatf("v%0d_cnt_nb", i), 32'(cnt_n), 32'(vt[i].e_cnt));
    end

    // Bypass vs stored-only read of r3 while it is being written.
    @(negedge clk);
    drive(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    check("byp_same_cycle", rd_data_b[31:0], 32'hDEADBEEF);
    check("nobyp_same_cycle", rd_data_n[31:0], 32'h0);
    @(posedge clk);
    #1;
    check("nobyp_next_cycle", rd_data_n[31:0], 32'hDEADBEEF);

    // Writing pending r10: bypass instance hides pending, stored-only instance still shows it.
    @(negedge clk);
    drive(2'b10, 5'd0, 32'h0, 5'd10, 32'h000000AA, 1'b0, 5'd0, 5'd10, 5'd4);
    #1;
    check("byp_pend_fwd", 32'(rd_pend_b), 32'b10);
    check("nobyp_pend_fwd", 32'(rd_pend_n), 32'b11);
    @(posedge clk);
    #1;
    check("clr_r10_cnt", 32'(cnt_b), 32'd1);
    check("clr_r10_pend", 32'(rd_pend_n), 32'b10);

    // Mid-cycle reset clears state with no clock edge; writes under reset are dropped.
    @(negedge clk);
    drive(2'b01, 5'd5, 32'h00005555, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd4);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_rd_r5", rd_data_b[31:0], 32'h0);
    check("rst_async_rd_r4", rd_data_b[63:32], 32'h0);
    check("rst_async_pend", 32'(rd_pend_b), 32'b00);
    check("rst_async_cnt", 32'(cnt_b), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_rd_r5", rd_data_n[31:0], 32'h0);
    check("rst_hold_cnt", 32'(cnt_n), 32'd0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    rd_addr = {5'd7, 5'd3};
    #1;
    check("post_rst_r3", rd_data_b[31:0], 32'h0);
    check("post_rst_r7", rd_data_b[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
